interrupt_controller: RTL

Memory-mapped 16-source interrupt controller that sits directly upstream of the CPU. It drives the CPU's `IRQ` and `IC[3:0]` inputs. It detects rising edges on peripheral request lines, latches them as pending, applies a mask, and arbitrates by fixed priority with strict nesting against in-service interrupts. Software services it through four words on the CPU's `A`/`D`/`W` bus.

---
 rtl/interrupt_controller.sv | 112 +++++++++++
 1 files changed

// File: rtl/interrupt_controller.sv
// 16-source edge-triggered interrupt controller with mask, pending, in-service nesting and a 4-word CPU register window.
// IRQ/IC are registered and appear one edge after pend; reads drive D combinationally, writes act on the next edge.
module interrupt_controller #(
  parameter logic [15:0] BASE_ADDR = 16'hFF00
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] SRC,
  input  logic [15:0] A,
  input  logic        W,
  inout  wire  [15:0] D,
  output logic        IRQ,
  output logic [3:0]  IC
);

  logic [15:0] prevSrc;
  logic [15:0] maskReg;
  logic [15:0] pendReg;
  logic [15:0] isrReg;

  logic        hit;
  logic        rdEn;
  logic        wrMask;
  logic        wrAck;
  logic        wrEoi;
  logic [15:0] clr;
  logic [15:0] rise;
  logic [15:0] isrNext;
  logic [15:0] rdDat;

  logic [15:0] cand;
  logic [3:0]  p;
  logic [4:0]  s;
  logic        request;

  assign rise = SRC & ~prevSrc;

  // Decode through if-statements so a floating address bus reads as no match.
  always_comb begin
    hit    = 1'b0;
    rdEn   = 1'b0;
    wrMask = 1'b0;
    wrAck  = 1'b0;
    wrEoi  = 1'b0;
    clr    = 16'd0;
    if (A[15:2] == BASE_ADDR[15:2]) hit = 1'b1;
    if (hit && !W) rdEn = 1'b1;
    if (hit && W) begin
      case (A[1:0])
        2'd0: wrMask = 1'b1;
        2'd1: clr = D;
        2'd2: begin
          wrAck = 1'b1;
          clr   = 16'd1 << D[3:0];
        end
        default: wrEoi = 1'b1;
      endcase
    end
  end

  always_comb begin
    isrNext = isrReg;
    if (wrAck) isrNext = isrReg | (16'd1 << D[3:0]);
    // x & (x-1) drops the lowest set bit and leaves zero untouched.
    if (wrEoi) isrNext = isrReg & (isrReg - 16'd1);
  end

  always_comb begin
    cand = pendReg & maskReg;
    p = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (cand[i]) p = 4'(i);
    end
    s = 5'd16;
    for (int i = 15; i >= 0; i--) begin
      if (isrReg[i]) s = 5'(i);
    end
    request = (cand != 16'd0) && ({1'b0, p} < s);
  end

  always_comb begin
    rdDat = 16'd0;
    case (A[1:0])
      2'd0:    rdDat = maskReg;
      2'd1:    rdDat = pendReg;
      2'd2:    rdDat = isrReg;
      default: rdDat = {IRQ, 11'd0, IC};
    endcase
  end

  assign D = rdEn ? rdDat : 16'hzzzz;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      // All-ones history keeps lines already high at release from firing.
      prevSrc <= 16'hFFFF;
      maskReg <= 16'd0;
      pendReg <= 16'd0;
      isrReg  <= 16'd0;
      IRQ     <= 1'b0;
      IC      <= 4'd0;
    end else begin
      prevSrc <= SRC;
      if (wrMask) maskReg <= D;
      pendReg <= (pendReg & ~clr) | rise;
      isrReg  <= isrNext;
      IRQ     <= request;
      IC      <= request ? p : 4'd0;
    end
  end

endmodule
